// File: rtl/lcd_pkg.sv
// Shared definitions for the Spartan-3E character LCD path: writer state encoding,
// 50 MHz timing defaults and HD44780 command bytes used by the init sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitHi,
        StGapHi,
        StWaitLo,
        StGapLo,
        StDone
    } wr_state_e;

    // Timing defaults at 50 MHz.
    localparam int unsigned NibbleGapCyclesDefault = 50;    // 1 us
    localparam int unsigned ByteGapCyclesDefault   = 2000;  // 40 us
    localparam int unsigned TimeoutCyclesDefault   = 256;
    localparam int unsigned CountWDefault          = 12;

    // HD44780 commands issued by the upstream init sequencer.
    localparam logic [7:0] LcdCmdFunctionSet4b = 8'h28;
    localparam logic [7:0] LcdCmdEntryModeInc  = 8'h06;
    localparam logic [7:0] LcdCmdDisplayOn     = 8'h0C;
    localparam logic [7:0] LcdCmdClearDisplay  = 8'h01;
    localparam logic [7:0] LcdCmdReturnHome    = 8'h02;

endpackage

// File: rtl/lcd_nibble_writer.sv
// Byte write stage for the 4-bit HD44780 bus: sends upper then lower nibble, steering the
// sibling enable-pulse generator through its reset and inserting settle gaps.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned NIBBLE_GAP_CYCLES = NibbleGapCyclesDefault,
    parameter int unsigned BYTE_GAP_CYCLES   = ByteGapCyclesDefault,
    parameter int unsigned TIMEOUT_CYCLES    = TimeoutCyclesDefault,
    parameter int unsigned COUNT_W           = CountWDefault
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iRS,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oEnableReset,
    input  logic       iEnableDone
);

    localparam logic [COUNT_W-1:0] NibbleLast  = COUNT_W'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] ByteLast    = COUNT_W'(BYTE_GAP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TimeoutLast = COUNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CountOne    = COUNT_W'(1);

    wr_state_e          state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         data_q, data_d;
    logic [3:0]         lo_q, lo_d;
    logic               rs_q, rs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               en_rst_q, en_rst_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            data_q   <= '0;
            lo_q     <= '0;
            rs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            lo_q     <= lo_d;
            rs_q     <= rs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_rst_q <= en_rst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        lo_d     = lo_q;
        rs_d     = rs_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        en_rst_d = en_rst_q;
        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    data_d   = iData[7:4];
                    lo_d     = iData[3:0];
                    rs_d     = iRS;
                    busy_d   = 1'b1;
                    en_rst_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StWaitHi;
                end
            end
            StWaitHi, StWaitLo: begin
                // A completion on the last timeout cycle still counts as success.
                if (iEnableDone) begin
                    en_rst_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = (state_q == StWaitHi) ? StGapHi : StGapLo;
                end else if (cnt_q == TimeoutLast) begin
                    en_rst_d = 1'b1;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CountOne;
                end
            end
            StGapHi: begin
                // Data and enable release move together so E sees the full setup window.
                if (cnt_q == NibbleLast) begin
                    data_d   = lo_q;
                    en_rst_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StWaitLo;
                end else begin
                    cnt_d = cnt_q + CountOne;
                end
            end
            StGapLo: begin
                if (cnt_q == ByteLast) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CountOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oError       = err_q;
    assign oLCD_Data    = data_q;
    assign oLCD_RS      = rs_q;
    assign oLCD_RW      = 1'b0;
    assign oEnableReset = en_rst_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Randomised bench for lcd_nibble_writer with a behavioural enable-pulser model and a
// transfer-level reference model of nibble order, latency and timeout.
module tb_lcd_nibble_writer;

    localparam int NGap = 50;
    localparam int BGap = 2000;
    localparam int TOut = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       oBusy, oDone, oError, oLCD_RS, oLCD_RW, oEnableReset;
    logic [3:0] oLCD_Data;
    logic       iEnableDone;

    int  n_checks = 0;
    int  n_fail = 0;

    // Pulser model: one-cycle done, pulse_delay cycles after the enable reset is released.
    int   pulse_delay = 20;
    int   rel_cnt = 0;
    logic model_done = 1'b0;
    logic inject_done = 1'b0;

    assign iEnableDone = model_done | inject_done;

    always #10 clk = ~clk;

    lcd_nibble_writer #(
        .NIBBLE_GAP_CYCLES(NGap),
        .BYTE_GAP_CYCLES  (BGap),
        .TIMEOUT_CYCLES   (TOut),
        .COUNT_W          (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iStart      (iStart),
        .iData       (iData),
        .iRS         (iRS),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oError      (oError),
        .oLCD_Data   (oLCD_Data),
        .oLCD_RS     (oLCD_RS),
        .oLCD_RW     (oLCD_RW),
        .oEnableReset(oEnableReset),
        .iEnableDone (iEnableDone)
    );

    always @(posedge clk) begin
        #1;
        if (!oEnableReset) begin
            rel_cnt    = rel_cnt + 1;
            model_done = (rel_cnt == pulse_delay);
        end else begin
            rel_cnt    = 0;
            model_done = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " busy"}, 32'(oBusy), 0);
        check_eq({tag, " done"}, 32'(oDone), 0);
        check_eq({tag, " err"}, 32'(oError), 0);
        check_eq({tag, " data"}, 32'(oLCD_Data), 0);
        check_eq({tag, " rs"}, 32'(oLCD_RS), 0);
        check_eq({tag, " rw"}, 32'(oLCD_RW), 0);
        check_eq({tag, " enrst"}, 32'(oEnableReset), 1);
    endtask

    // One byte transfer. inj_k/restart_k < 0 disable the disturbance; tail = idle cycles after.
    task automatic run_write(input string tag, input logic [7:0] data, input logic rs,
                             input int delay, input int inj_k, input int restart_k,
                             input int tail);
        logic [3:0] exp_nib[$];
        logic [3:0] got_nib[$];
        logic       got_rs[$];
        int         exp_lat, done_k, extra;
        logic       exp_err, got_err, prev_er;

        exp_err = (delay > TOut);
        exp_nib.push_back(data[7:4]);
        if (exp_err) begin
            exp_lat = TOut;
        end else begin
            exp_lat = 2 * delay + NGap + BGap;
            exp_nib.push_back(data[3:0]);
        end
        pulse_delay = delay;
        iData   = data;
        iRS     = rs;
        iStart  = 1'b1;
        prev_er = 1'b1;
        done_k  = -1;
        got_err = 1'b0;
        for (int k = 0; k <= exp_lat + 50; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                iStart = 1'b0;
                iData  = 8'($urandom);
                iRS    = ~rs;
            end
            if (k == 1) check_eq({tag, " busy"}, 32'(oBusy), 1);
            if (restart_k >= 0) begin
                iStart = (k == restart_k);
                if (k == restart_k) iData = 8'hFF;
            end
            if (inj_k >= 0) inject_done = (k == inj_k);
            if (prev_er && !oEnableReset) begin
                got_nib.push_back(oLCD_Data);
                got_rs.push_back(oLCD_RS);
            end
            prev_er = oEnableReset;
            if (oDone) begin
                done_k  = k;
                got_err = oError;
                check_eq({tag, " busy@done"}, 32'(oBusy), 0);
                check_eq({tag, " enrst@done"}, 32'(oEnableReset), 1);
                break;
            end
        end
        iStart      = 1'b0;
        inject_done = 1'b0;
        check_eq({tag, " latency"}, 32'(done_k), 32'(exp_lat));
        check_eq({tag, " error"}, 32'(got_err), 32'(exp_err));
        check_eq({tag, " nibbles"}, 32'(got_nib.size()), 32'(exp_nib.size()));
        for (int i = 0; i < got_nib.size() && i < exp_nib.size(); i++) begin
            check_eq({tag, " nibble"}, 32'(got_nib[i]), 32'(exp_nib[i]));
            check_eq({tag, " rs"}, 32'(got_rs[i]), 32'(rs));
        end
        extra = 0;
        for (int t = 0; t < tail; t++) begin
            @(posedge clk);
            #1;
            if (oDone) extra++;
        end
        check_eq({tag, " extra done"}, 32'(extra), 0);
        check_eq({tag, " idle busy"}, 32'(oBusy), 0);
    endtask

    initial begin
        int seen;
        // Reset held low.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stray enable-done in IDLE.
        inject_done = 1'b1;
        @(posedge clk);
        #1;
        inject_done = 1'b0;
        check_eq("idle inject busy", 32'(oBusy), 0);
        check_eq("idle inject enrst", 32'(oEnableReset), 1);

        run_write("w28", 8'h28, 1'b0, 20, -1, -1, 1);
        // Stray done in GAP_HI, second start ignored, only one done over a long tail.
        run_write("w41", 8'h41, 1'b1, 20, 30, 100, 2300);
        run_write("hang", 8'hA5, 1'b1, 1000, -1, -1, 1);
        run_write("edge256", 8'h5A, 1'b0, TOut, -1, -1, 1);
        run_write("edge257", 8'h3C, 1'b1, TOut + 1, -1, -1, 1);
        run_write("fast", 8'h96, 1'b0, 1, -1, -1, 1);

        // Reset during GAP_LO abandons the transfer.
        pulse_delay = 20;
        iData  = 8'h33;
        iRS    = 1'b1;
        iStart = 1'b1;
        seen   = 0;
        for (int k = 0; k < 190; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) iStart = 1'b0;
            if (oDone) seen++;
        end
        check_eq("abort busy before", 32'(oBusy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) begin
            @(posedge clk);
            #1;
            if (oDone) seen++;
        end
        check_eq("abort done", 32'(seen), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_write("w0C", 8'h0C, 1'b0, 20, -1, -1, 1);

        for (int i = 0; i < 4; i++) begin
            run_write("rand", 8'($urandom), 1'($urandom), int'($urandom_range(1, 60)), -1, -1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

- Byte-level write stage for the Spartan-3E character LCD on its 4-bit data bus.
- Accepts one byte plus RS through a start/busy/done handshake. Drives the upper nibble, then the lower nibble, onto the LCD data lines.
- Sequences the `Module_Write_Enable` pulse generator once per nibble by releasing and re-asserting that block's reset, then inserts the mandatory inter-nibble and post-byte settle gaps.
- Sits between the LCD init/command sequencer (upstream) and `Module_Write_Enable` (downstream, sibling instance).

## Interface
Parameters:
- NIBBLE_GAP_CYCLES, 50: settle cycles after upper nibble (1 µs at 50 MHz)
- BYTE_GAP_CYCLES, 2000: settle cycles after lower nibble (40 µs at 50 MHz)
- TIMEOUT_CYCLES, 256: max cycles waiting for iEnableDone per nibble
- COUNT_W, 12: gap/timeout counter width

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low
- iStart  in  1  request a byte write; sampled only in IDLE
- iData  in  8  byte to write
- iRS  in  1  register select (0 command, 1 data)
- oBusy  out  1  transfer in progress
- oDone  out  1  one-cycle pulse at end of transfer
- oError  out  1  one-cycle pulse, coincident with oDone, on enable timeout
- oLCD_Data  out  4  LCD data nibble (SF_D[11:8])
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  constant 0 (write only)
- oEnableReset  out  1  synchronous reset to Module_Write_Enable (1 = hold idle)
- iEnableDone  in  1  completion flag from Module_Write_Enable

## Operation
- All outputs registered.
- Reset values: oBusy 0, oDone 0, oError 0, oLCD_Data 0, oLCD_RS 0, oLCD_RW 0, oEnableReset 1; state IDLE; counter 0.
- States and transitions:
  - IDLE: if iStart, latch iData/iRS, drive oLCD_Data = iData[7:4] and oLCD_RS = iRS, set oBusy = 1 and oEnableReset = 0, go to WAIT_HI.
  - WAIT_HI: oEnableReset = 0; counter increments. On iEnableDone, set oEnableReset = 1, clear counter, go to GAP_HI. If the counter reaches TIMEOUT_CYCLES-1 first, go to DONE with error.
  - GAP_HI: oEnableReset = 1; hold for NIBBLE_GAP_CYCLES cycles. On exit, drive oLCD_Data = lower nibble, set oEnableReset = 0, go to WAIT_LO.
  - WAIT_LO: same as WAIT_HI; on iEnableDone go to GAP_LO.
  - GAP_LO: hold for BYTE_GAP_CYCLES cycles, then go to DONE.
  - DONE: oDone = 1 for one cycle (oError = 1 if entered on timeout), oBusy = 0, go to IDLE.
- oLCD_Data and oLCD_RS change only while oEnableReset = 1 or on the release edge. This guarantees ≥4 cycles of setup before E rises.
- Hold time is guaranteed because data changes only after the pulse completes.

## Timing
- Counter runs 0..N-1; a gap state exits on the cycle count == N-1, so it lasts exactly N cycles.
- COUNT_W ≥ clog2(max(BYTE_GAP_CYCLES, TIMEOUT_CYCLES)). All cycle parameters are ≥ 1.
- Latency from the accept edge to oDone = tHI + NIBBLE_GAP_CYCLES + tLO + BYTE_GAP_CYCLES cycles, where tHI and tLO are cycles spent in the WAIT states.
- Minimum spacing between accepted starts is that latency + 2 cycles.
- iStart in any state other than IDLE is ignored; iData/iRS changes after accept have no effect.
- iEnableDone outside the WAIT states is ignored.
- iEnableDone on the final timeout cycle: done wins, no error.
- Reset asserted mid-transfer forces all reset values immediately (asynchronous), including oEnableReset = 1. The transfer is abandoned with no oDone. The next iStart after release is served normally.

## Structure
- Shared package lcd_pkg holds:
  - state encodings
  - default gap and timeout constants for 50 MHz
  - HD44780 command byte constants used by the upstream init sequencer
- Single module, no sub-module. Module_Write_Enable is instantiated beside it by the parent LCD controller, not inside it.

## Test plan
The bench model of the pulser asserts iEnableDone for one cycle, 20 cycles after oEnableReset falls.
- Reset held low → every output at its reset value; oEnableReset = 1.
- iStart with iData 0x28, iRS 0 → oLCD_Data 0x2 then 0x8; RS 0; two release windows of 20 cycles separated by a 50-cycle gap; single oDone 2090 cycles after the accept edge; oError 0.
- iData 0x41, iRS 1, second iStart with 0xFF at cycle 100 → nibbles 0x4, 0x1 only; RS 1; exactly one oDone.
- Model never returns iEnableDone → oDone and oError pulse together 256 cycles after release; oEnableReset back to 1; next start accepted.
- Reset pulsed low during GAP_LO → outputs return to reset values immediately, no oDone; a fresh write of 0x0C completes normally.
- iEnableDone pulsed in IDLE and in GAP_HI → no state change, no extra nibble, timing unchanged.
